mask_tile_controller: RTL and testbench

- Next-generation convolution-unit controller for the skeletonization pipeline.
- Streams a rectangular IMG_W x IMG_H pixel tile into a bank of LANES external kernel units and waits a fixed compute time.
- Drains the tile back as a pixel stream. Border pixels are forced to zero, and the Harris-corner flag travels with each pixel.
- Compared with the previous unit, it adds full-rate operation, non-square tiles, a configurable border width, valid/ready handshakes with backpressure, and an asynchronous reset.

---
 rtl/mask_tile_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_mask_tile_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_tile_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mask_tile_controller
//  Purpose  : Streams an IMG_W x IMG_H pixel tile into a bank of LANES kernel
//             units, waits COMPUTE_CYC cycles, then drains the tile back as a
//             valid/ready pixel stream with the border forced to zero and the
//             per-pixel Harris flag attached.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             start               - begin a tile (sampled only when idle)
//             in_valid/in_ready/in_data      - input pixel stream
//             ku_we/ku_addr/ku_wdata         - kernel-unit write port
//             ku_rdata/ku_flag               - kernel-unit read data (comb.)
//             out_valid/out_ready/out_data/out_flag/out_addr/out_last
//                                            - output pixel stream
//             busy, done          - status
//  Revision : 1.0 - initial release
// ============================================================================
module mask_tile_controller #(
   parameter int IMG_W       = 8,
   parameter int IMG_H       = 8,
   parameter int PIX_W       = 8,
   parameter int PAD         = 1,
   parameter int LANES       = 24,
   parameter int COMPUTE_CYC = 4,
   parameter int ADDR_W      = $clog2(IMG_W*IMG_H),
   parameter int LADDR_W     = $clog2((IMG_W*IMG_H+LANES-1)/LANES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [PIX_W-1:0]       in_data,
   output logic                   in_ready,
   output logic [LANES-1:0]       ku_we,
   output logic [LADDR_W-1:0]     ku_addr,
   output logic [PIX_W-1:0]       ku_wdata,
   input  logic [LANES*PIX_W-1:0] ku_rdata,
   input  logic [LANES-1:0]       ku_flag,
   output logic                   out_valid,
   output logic [PIX_W-1:0]       out_data,
   output logic                   out_flag,
   output logic [ADDR_W-1:0]      out_addr,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int NPIX   = IMG_W*IMG_H;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int CYC_W  = (COMPUTE_CYC > 0) ? $clog2(COMPUTE_CYC+1) : 1;

   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NPIX-1);
   localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES-1);
   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_W-1);
   localparam logic [ROW_W-1:0]  ROW_LO   = ROW_W'(PAD);
   localparam logic [ROW_W-1:0]  ROW_HI   = ROW_W'(IMG_H-PAD);
   localparam logic [COL_W-1:0]  COL_LO   = COL_W'(PAD);
   localparam logic [COL_W-1:0]  COL_HI   = COL_W'(IMG_W-PAD);
   localparam logic [CYC_W-1:0]  CYC_END  = CYC_W'(COMPUTE_CYC);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]         state_q, state_d;

   // One position counter set serves both load and drain: it is cleared when
   // the final index advances, so each phase starts from pixel 0.
   logic [ADDR_W-1:0]  idx_q,   idx_d;
   logic [LANE_W-1:0]  lane_q,  lane_d;
   logic [LADDR_W-1:0] laddr_q, laddr_d;
   logic [ROW_W-1:0]   row_q,   row_d;
   logic [COL_W-1:0]   col_q,   col_d;
   logic [CYC_W-1:0]   cyc_q,   cyc_d;

   logic [LANES-1:0]   we_q,    we_d;
   logic [LADDR_W-1:0] waddr_q, waddr_d;
   logic [PIX_W-1:0]   wdata_q, wdata_d;

   logic               ovalid_q, ovalid_d;
   logic [PIX_W-1:0]   odata_q,  odata_d;
   logic               oflag_q,  oflag_d;
   logic [ADDR_W-1:0]  oaddr_q,  oaddr_d;
   logic               olast_q,  olast_d;
   logic               done_q,   done_d;

   logic in_hs, idx_last, drain_ld, out_fin, advance, border;

   assign in_hs    = (state_q == S_LOAD) && in_valid;
   assign idx_last = (idx_q == IDX_LAST);
   // Output register refills when empty, or when the held beat is taken and
   // it was not the final one (the final beat ends the tile instead).
   assign drain_ld = (state_q == S_DRAIN) && (!ovalid_q || (out_ready && !olast_q));
   assign out_fin  = ovalid_q && out_ready && olast_q;
   assign advance  = in_hs || drain_ld;
   assign border   = (row_q < ROW_LO) || (row_q >= ROW_HI) ||
                     (col_q < COL_LO) || (col_q >= COL_HI);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start)                state_d = S_LOAD;
         S_LOAD:    if (in_hs && idx_last)    state_d = S_COMPUTE;
         // The first COMPUTE cycle carries the last write pulse; counting
         // starts there so the wait is measured after that pulse.
         S_COMPUTE: if (cyc_q == CYC_END)     state_d = S_DRAIN;
         S_DRAIN:   if (out_fin)              state_d = S_IDLE;
         default:                             state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (state_q == S_LOAD);
      busy     = (state_q != S_IDLE);
      ku_addr  = (state_q == S_DRAIN) ? laddr_q : waddr_q;
   end

   // ---------------- Datapath next values ----------------
   always_comb begin
      idx_d    = idx_q;
      lane_d   = lane_q;
      laddr_d  = laddr_q;
      row_d    = row_q;
      col_d    = col_q;
      cyc_d    = (state_q == S_COMPUTE) ? cyc_q + 1'b1 : '0;
      we_d     = '0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      ovalid_d = ovalid_q;
      odata_d  = odata_q;
      oflag_d  = oflag_q;
      oaddr_d  = oaddr_q;
      olast_d  = olast_q;
      done_d   = out_fin;

      if (advance) begin
         if (idx_last) begin
            idx_d   = '0;
            lane_d  = '0;
            laddr_d = '0;
            row_d   = '0;
            col_d   = '0;
         end else begin
            idx_d = idx_q + 1'b1;
            if (lane_q == LANE_MAX) begin
               lane_d  = '0;
               laddr_d = laddr_q + 1'b1;
            end else begin
               lane_d  = lane_q + 1'b1;
            end
            if (col_q == COL_MAX) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end

      if (in_hs) begin
         we_d    = LANES'(1) << lane_q;
         waddr_d = laddr_q;
         wdata_d = in_data;
      end

      if (drain_ld) begin
         ovalid_d = 1'b1;
         odata_d  = border ? '0 : ku_rdata[lane_q*PIX_W +: PIX_W];
         oflag_d  = border ? 1'b0 : ku_flag[lane_q];
         oaddr_d  = idx_q;
         olast_d  = idx_last;
      end else if (out_fin) begin
         ovalid_d = 1'b0;
      end
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         lane_q   <= '0;
         laddr_q  <= '0;
         row_q    <= '0;
         col_q    <= '0;
         cyc_q    <= '0;
         we_q     <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         ovalid_q <= 1'b0;
         odata_q  <= '0;
         oflag_q  <= 1'b0;
         oaddr_q  <= '0;
         olast_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         lane_q   <= lane_d;
         laddr_q  <= laddr_d;
         row_q    <= row_d;
         col_q    <= col_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         ovalid_q <= ovalid_d;
         odata_q  <= odata_d;
         oflag_q  <= oflag_d;
         oaddr_q  <= oaddr_d;
         olast_q  <= olast_d;
         done_q   <= done_d;
      end
   end

   assign ku_we     = we_q;
   assign ku_wdata  = wdata_q;
   assign out_valid = ovalid_q;
   assign out_data  = odata_q;
   assign out_flag  = oflag_q;
   assign out_addr  = oaddr_q;
   assign out_last  = olast_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mask_tile_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mask_tile_controller
//  Purpose  : Self-checking bench for mask_tile_controller on a 6x5 tile with
//             4 kernel lanes. A behavioural kernel bank echoes stored pixels;
//             expected writes and output beats come from plain index
//             arithmetic on a per-tile pixel array.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mask_tile_controller;

   localparam int W   = 6;
   localparam int H   = 5;
   localparam int P   = 1;
   localparam int L   = 4;
   localparam int CC  = 3;
   localparam int PW  = 8;
   localparam int N   = W*H;
   localparam int AW  = $clog2(N);
   localparam int LAW = $clog2((N+L-1)/L);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            in_valid = 1'b0;
   logic [PW-1:0]   in_data = '0;
   logic            in_ready;
   logic [L-1:0]    ku_we;
   logic [LAW-1:0]  ku_addr;
   logic [PW-1:0]   ku_wdata;
   logic [L*PW-1:0] ku_rdata;
   logic [L-1:0]    ku_flag;
   logic            out_valid;
   logic [PW-1:0]   out_data;
   logic            out_flag;
   logic [AW-1:0]   out_addr;
   logic            out_last;
   logic            out_ready = 1'b0;
   logic            busy;
   logic            done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [PW-1:0] pix [N];
   logic [PW-1:0] mem [L][1<<LAW];
   logic          flag_xor = 1'b0;

   always #5 clk = ~clk;

   mask_tile_controller #(
      .IMG_W(W), .IMG_H(H), .PIX_W(PW), .PAD(P), .LANES(L), .COMPUTE_CYC(CC),
      .ADDR_W(AW), .LADDR_W(LAW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ku_we(ku_we), .ku_addr(ku_addr), .ku_wdata(ku_wdata),
      .ku_rdata(ku_rdata), .ku_flag(ku_flag),
      .out_valid(out_valid), .out_data(out_data), .out_flag(out_flag),
      .out_addr(out_addr), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   // Kernel bank model: writes on ku_we, combinational echo read.
   always @(posedge clk) begin
      for (int j = 0; j < L; j++)
         if (ku_we[j]) mem[j][ku_addr] <= ku_wdata;
   end

   always_comb begin
      ku_rdata = '0;
      ku_flag  = '0;
      for (int j = 0; j < L; j++) begin
         ku_rdata[j*PW +: PW] = mem[j][ku_addr];
         ku_flag[j]           = mem[j][ku_addr][0] ^ flag_xor;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic bit is_border(input int k);
      int r, c;
      r = k / W;
      c = k % W;
      return (r < P) || (r >= H-P) || (c < P) || (c >= W-P);
   endfunction

   // vmode: 0 continuous, 1 alternate, 2 random in_valid
   // rmode: 0 out_ready high, 1 random, 2 three-cycle stall on beat 10
   // rst_k: >=0 asserts reset while that beat is presented
   task automatic run_tile(input int vmode, input int rmode, input int rst_k, input bit seq_pix);
      int hs, wr, beats, dones, post, last_hs, last_we, last_beat, stall10, pres10;
      bit first_out, prev_hold, fin;
      logic [PW-1:0] pd;
      logic [AW-1:0] pa;
      logic pf, pl;
      logic [PW-1:0] ed;
      logic ef;
      hs = 0; wr = 0; beats = 0; dones = 0; post = 0; stall10 = 0; pres10 = 0;
      last_hs = -10; last_we = -10; last_beat = -10;
      first_out = 0; prev_hold = 0; fin = 0;
      pd = '0; pa = '0; pf = 0; pl = 0;
      for (int k = 0; k < N; k++) pix[k] = seq_pix ? PW'(k+1) : PW'($urandom);
      flag_xor = seq_pix ? 1'b0 : 1'($urandom);

      for (int t = 0; t < 3000 && !fin; t++) begin
         @(negedge clk);
         cyc++;
         start = (t == 0) ? 1'b1 : (busy ? 1'($urandom) : 1'b0);
         if (hs < N) begin
            case (vmode)
               0:       in_valid = 1'b1;
               1:       in_valid = 1'(t % 2);
               default: in_valid = 1'($urandom);
            endcase
            in_data = pix[hs];
         end else begin
            in_valid = 1'($urandom);
            in_data  = PW'($urandom);
         end
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
               if (out_valid && out_addr == AW'(10) && stall10 < 3) begin
                  out_ready = 1'b0;
                  stall10++;
               end else begin
                  out_ready = 1'b1;
               end
            end
         endcase
         #1;

         if (rst_k >= 0 && out_valid && out_addr == AW'(rst_k)) begin
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy",      32'(busy),      0);
            chk("rst_ku_we",     32'(ku_we),     0);
            chk("rst_in_ready",  32'(in_ready),  0);
            start = 0; in_valid = 0; out_ready = 0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end

         // Write port
         if (ku_we != '0) begin
            if (wr < N) begin
               chk("ku_we",    32'(ku_we),    32'(1 << (wr % L)));
               chk("ku_addr",  32'(ku_addr),  32'(wr / L));
               chk("ku_wdata", 32'(ku_wdata), 32'(pix[wr]));
            end else begin
               chk("ku_we_extra", 32'(ku_we), 0);
            end
            last_we = cyc;
            wr++;
         end
         if (hs == N && last_hs == cyc-1) chk("in_ready_drop", 32'(in_ready), 0);
         if (in_valid && in_ready) begin
            hs++;
            if (hs == N) last_hs = cyc;
         end

         // Output stream
         if (out_valid && !first_out) begin
            first_out = 1;
            chk("drain_latency", 32'(cyc - last_we), 32'(CC + 2));
         end
         if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data",  32'(out_data),  32'(pd));
            chk("hold_addr",  32'(out_addr),  32'(pa));
            chk("hold_flag",  32'(out_flag),  32'(pf));
            chk("hold_last",  32'(out_last),  32'(pl));
         end
         prev_hold = out_valid && !out_ready;
         pd = out_data; pa = out_addr; pf = out_flag; pl = out_last;
         if (out_valid && out_addr == AW'(10)) pres10++;
         if (out_valid && out_ready) begin
            if (beats < N) begin
               ed = is_border(beats) ? '0 : pix[beats];
               ef = is_border(beats) ? 1'b0 : (pix[beats][0] ^ flag_xor);
               chk("beat_addr", 32'(out_addr), 32'(beats));
               chk("beat_data", 32'(out_data), 32'(ed));
               chk("beat_flag", 32'(out_flag), 32'(ef));
               chk("beat_last", 32'(out_last), 32'(beats == N-1));
            end else begin
               chk("beat_extra", 32'(out_valid), 0);
            end
            if (out_last) last_beat = cyc;
            beats++;
         end
         if (done) begin
            chk("done_timing", 32'(cyc - last_beat), 1);
            chk("done_busy",   32'(busy), 0);
            dones++;
         end
         if (dones > 0 && !done) begin
            chk("idle_busy",      32'(busy),      0);
            chk("idle_out_valid", 32'(out_valid), 0);
            post++;
            if (post >= 2) fin = 1;
         end
      end

      start = 0; in_valid = 0; out_ready = 0;
      chk("tile_handshakes", 32'(hs),    N);
      chk("tile_writes",     32'(wr),    N);
      chk("tile_beats",      32'(beats), N);
      chk("tile_dones",      32'(dones), 1);
      if (rmode == 2) chk("stall_k10_cycles", 32'(pres10), 4);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_in_ready",  32'(in_ready),  0);
      chk("reset_ku_we",     32'(ku_we),     0);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_done",      32'(done),      0);
      chk("reset_busy",      32'(busy),      0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_tile(0, 0, -1, 1);
      run_tile(1, 2, -1, 1);
      run_tile(0, 0, 12, 1);
      run_tile(0, 0, -1, 1);
      for (int i = 0; i < 5; i++)
         run_tile($urandom_range(0, 2), $urandom_range(0, 2), -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
